// File: rtl/snake_pkg.sv
// snake_pkg: tile encoding, map geometry and the requester command record shared by the tile-map logic
package snake_pkg;

    typedef enum logic [2:0] {
        EMPTY  = 3'd0,
        WALL   = 3'd1,
        SNAKE1 = 3'd2,
        SNAKE2 = 3'd3,
        POINT  = 3'd4
    } tile_t;

    localparam int MAP_W      = 40;
    localparam int MAP_H      = 30;
    localparam int TILE_SHIFT = 4;
    localparam int MAP_ADDR_W = 11;

    typedef struct packed {
        logic                  we;
        logic [MAP_ADDR_W-1:0] addr;
        tile_t                 wdata;
    } map_req_t;

endpackage

// File: rtl/vga_pkg.sv
// vga_pkg: frame timing totals (800x600 visible inside a 1056x628 frame)
package vga_pkg;

    localparam int H_TOTAL = 1056;
    localparam int V_TOTAL = 628;

endpackage

// File: rtl/vga_if.sv
// vga_if: VGA timing bundle; consumers use the "in" modport
interface vga_if;

    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hblnk;
    logic        vblnk;

    modport in (input hcount, input vcount, input hblnk, input vblnk);

endinterface

// File: rtl/tile_rr_arb.sv
// tile_rr_arb: two-port round-robin grant for the free RAM slots
// Ports: i_clk, i_rst_n (sync, active-low); i_valid per-port request; i_slot_free slot available;
//        o_ready one-hot accept strobe; o_gnt_id selected port (meaningful when o_ready != 0)
module tile_rr_arb (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_valid,
    input  logic       i_slot_free,
    output logic [1:0] o_ready,
    output logic       o_gnt_id
);

    // last granted port; resetting to 1 makes port 0 win the first contest
    logic r_last;

    always_comb begin
        o_gnt_id = (&i_valid) ? ~r_last : i_valid[1];
        o_ready  = i_slot_free ? (o_gnt_id ? {i_valid[1], 1'b0} : {1'b0, i_valid[0]}) : 2'b00;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_last <= 1'b1;
        else if (|o_ready)
            r_last <= o_gnt_id;
    end

endmodule

// File: rtl/tile_map_arbiter.sv
// tile_map_arbiter: shares the single-port tile-map RAM between the VGA tile fetcher and two requesters
// Ports: i_clk, i_rst_n (sync, active-low); i_vga timing; o_act_tile tile under the current pixel;
//        o_mem_addr/o_mem_we/o_mem_wdata registered RAM command, i_mem_rdata valid one cycle after address;
//        i_req_valid/i_req_we/i_req_addr/i_req_wdata + o_req_ready requester handshake;
//        o_rsp_valid per-port read pulse with shared o_rsp_rdata
module tile_map_arbiter
    import snake_pkg::*;
    import vga_pkg::*;
(
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    vga_if.in                          i_vga,
    output tile_t                      o_act_tile,
    output logic [MAP_ADDR_W-1:0]      o_mem_addr,
    output logic                       o_mem_we,
    output tile_t                      o_mem_wdata,
    input  tile_t                      i_mem_rdata,
    input  logic [1:0]                 i_req_valid,
    input  logic [1:0]                 i_req_we,
    input  logic [1:0][MAP_ADDR_W-1:0] i_req_addr,
    input  tile_t [1:0]                i_req_wdata,
    output logic [1:0]                 o_req_ready,
    output logic [1:0]                 o_rsp_valid,
    output tile_t                      o_rsp_rdata
);

    localparam int MAP_SIZE = MAP_W * MAP_H;

    if (H_TOTAL % (1 << TILE_SHIFT) != 0) begin : g_htotal_chk
        $fatal(1, "H_TOTAL must be a multiple of the tile size");
    end
    if ((1 << MAP_ADDR_W) < MAP_SIZE) begin : g_addr_chk
        $fatal(1, "MAP_ADDR_W too small for the map");
    end

    logic [11:0]           w_h3, w_tx, w_col;
    logic [10:0]           w_ty, w_row;
    logic                  w_wrap, w_slot, w_on_map, w_fetch, w_free, w_gnt, w_id, w_oob;
    logic [MAP_ADDR_W-1:0] w_faddr;
    map_req_t              w_sel;

    logic [MAP_ADDR_W-1:0] r_mem_addr;
    logic                  r_mem_we;
    tile_t                 r_mem_wdata, r_act_tile;
    logic                  r_fv1, r_fv2, r_fhit1, r_fhit2;
    logic                  r_rv1, r_rv2, r_rid1, r_rid2, r_roob1, r_roob2;

    // Fetch runs 3 pixels ahead: address out, RAM read, capture, so the tile
    // lands in act_tile exactly on the tile boundary.
    always_comb begin
        w_h3     = {1'b0, i_vga.hcount} + 12'd3;
        w_wrap   = w_h3 >= 12'(H_TOTAL);
        w_tx     = w_wrap ? w_h3 - 12'(H_TOTAL) : w_h3;
        w_ty     = w_wrap ? ((i_vga.vcount == 11'(V_TOTAL - 1)) ? 11'd0 : i_vga.vcount + 11'd1) : i_vga.vcount;
        w_slot   = w_h3[TILE_SHIFT-1:0] == '0;
        w_col    = w_tx >> TILE_SHIFT;
        w_row    = w_ty >> TILE_SHIFT;
        // without a wrap the target shares this line, so current blanking applies to it as well
        w_on_map = (w_col < 12'(MAP_W)) && (w_row < 11'(MAP_H)) && !(!w_wrap && (i_vga.hblnk || i_vga.vblnk));
        w_fetch  = w_slot && w_on_map;
        w_free   = i_rst_n && !w_fetch;
        w_faddr  = MAP_ADDR_W'(int'(w_row) * MAP_W + int'(w_col));
    end

    tile_rr_arb u_arb (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_req_valid),
        .i_slot_free (w_free),
        .o_ready     (o_req_ready),
        .o_gnt_id    (w_id)
    );

    always_comb begin
        w_gnt = |o_req_ready;
        w_sel = '{we: i_req_we[w_id], addr: i_req_addr[w_id], wdata: i_req_wdata[w_id]};
        w_oob = w_sel.addr >= MAP_ADDR_W'(MAP_SIZE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= EMPTY;
            r_act_tile  <= EMPTY;
            r_fv1       <= 1'b0;
            r_fv2       <= 1'b0;
            r_fhit1     <= 1'b0;
            r_fhit2     <= 1'b0;
            r_rv1       <= 1'b0;
            r_rv2       <= 1'b0;
            r_rid1      <= 1'b0;
            r_rid2      <= 1'b0;
            r_roob1     <= 1'b0;
            r_roob2     <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            if (w_fetch) begin
                r_mem_addr <= w_faddr;
            end else if (w_gnt) begin
                // out-of-map requests never reach the RAM; the address bus keeps its value
                if (!w_oob)
                    r_mem_addr <= w_sel.addr;
                r_mem_we    <= w_sel.we && !w_oob;
                r_mem_wdata <= w_sel.wdata;
            end
            r_fv1   <= w_slot;
            r_fhit1 <= w_on_map;
            r_fv2   <= r_fv1;
            r_fhit2 <= r_fhit1;
            if (r_fv2)
                r_act_tile <= r_fhit2 ? i_mem_rdata : EMPTY;
            r_rv1   <= w_gnt && !w_sel.we;
            r_rid1  <= w_id;
            r_roob1 <= w_oob;
            r_rv2   <= r_rv1;
            r_rid2  <= r_rid1;
            r_roob2 <= r_roob1;
        end
    end

    assign o_mem_addr  = r_mem_addr;
    assign o_mem_we    = r_mem_we;
    assign o_mem_wdata = r_mem_wdata;
    assign o_act_tile  = r_act_tile;
    assign o_rsp_valid = {r_rv2 && r_rid2, r_rv2 && !r_rid2};
    assign o_rsp_rdata = (r_rv2 && !r_roob2) ? i_mem_rdata : EMPTY;

endmodule
